// File: rtl/mem_load_pkg.sv
// Shared definitions for the load unit: op encodings, FSM states, data width default.
package mem_load_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef logic [1:0] op_t;
    localparam op_t OP_LDW = 2'd0;
    localparam op_t OP_LDB = 2'd1;
    localparam op_t OP_LDI = 2'd2;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t READ1 = 2'd1;
    localparam state_t READ2 = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/ld_format.sv
// Load data formatter: full word for LDW/LDI, sign-extended byte for LDB.
module ld_format
    import mem_load_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       op,
    input  logic             addr_lsb,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] data
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = addr_lsb ? word[15:8] : word[7:0];
        if (op == OP_LDB) begin
            data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
        end else begin
            data = word;
        end
    end

endmodule

// File: rtl/mem_load_unit.sv
// Pipeline load unit: word, byte and indirect loads over a wait-state memory port.
module mem_load_unit
    import mem_load_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_addr,
    output logic             req_ready,
    input  logic             flush,
    output logic             mem_read,
    output logic [WIDTH-1:0] mem_address,
    input  logic             mem_resp,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             stall
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             dropped_q, dropped_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0] fmt_data;
    logic             drop_now;

    ld_format #(
        .WIDTH (WIDTH)
    ) u_ld_format (
        .op       (op_q),
        .addr_lsb (addr_q[0]),
        .word     (mem_rdata),
        .data     (fmt_data)
    );

    // A flush during a read only marks the transaction; the bus access still completes.
    assign drop_now = dropped_q | flush;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        dropped_d  = dropped_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    state_d   = READ1;
                    op_d      = (req_op == OP_LDB || req_op == OP_LDI) ? req_op : OP_LDW;
                    addr_d    = req_addr;
                    dropped_d = 1'b0;
                end
            end
            READ1: begin
                dropped_d = drop_now;
                if (mem_resp) begin
                    if (op_q == OP_LDI && !drop_now) begin
                        addr_d  = mem_rdata;
                        state_d = READ2;
                    end else begin
                        if (!drop_now) begin
                            rsp_data_d = fmt_data;
                        end
                        state_d = DONE;
                    end
                end
            end
            READ2: begin
                dropped_d = drop_now;
                if (mem_resp) begin
                    if (!drop_now) begin
                        rsp_data_d = fmt_data;
                    end
                    state_d = DONE;
                end
            end
            default: begin
                state_d   = IDLE;
                dropped_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_LDW;
            addr_q     <= '0;
            dropped_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            dropped_q  <= dropped_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign mem_read    = (state_q == READ1) || (state_q == READ2);
    assign mem_address = {addr_q[WIDTH-1:1], 1'b0};
    assign rsp_valid   = (state_q == DONE) && !dropped_q && !flush;
    assign rsp_data    = rsp_data_q;
    assign stall       = ((state_q == IDLE) && req_valid) || mem_read;

endmodule

// File: doc/mem_load_unit.md
MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data and address width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit, meaning the pipeline presents a load request.
REQ-005 The block SHALL have port req_op, input, 2 bits, selecting OP_LDW=0, OP_LDB=1 or OP_LDI=2; value 3 is treated as OP_LDW.
REQ-006 The block SHALL have port req_addr, input, WIDTH bits, the byte address of the load.
REQ-007 The block SHALL have port req_ready, output, 1 bit, meaning a request is accepted this cycle.
REQ-008 The block SHALL have port flush, input, 1 bit, meaning the pipeline discards the in-flight load.
REQ-009 The block SHALL have port mem_read, output, 1 bit, the memory read strobe.
REQ-010 The block SHALL have port mem_address, output, WIDTH bits, the word-aligned memory address.
REQ-011 The block SHALL have port mem_resp, input, 1 bit, meaning memory completes the read this cycle.
REQ-012 The block SHALL have port mem_rdata, input, WIDTH bits, the read data, valid only while mem_resp=1.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit, a one-cycle pulse meaning rsp_data holds the load result.
REQ-014 The block SHALL have port rsp_data, output, WIDTH bits, the formatted load result.
REQ-015 The block SHALL have port stall, output, 1 bit, meaning the pipeline holds its MEM stage.

Function
REQ-016 The FSM SHALL have states IDLE, READ1, READ2 and DONE.
REQ-017 In IDLE, req_ready SHALL equal 1 and a request SHALL be accepted when req_valid=1 and flush=0, latching op and address and moving to READ1.
REQ-018 In READ1 and READ2, mem_read SHALL be 1 and mem_address SHALL be the latched address with bit 0 cleared, both held stable until mem_resp=1.
REQ-019 On mem_resp=1 in READ1 with op OP_LDI, mem_rdata SHALL become the new latched address and the FSM SHALL move to READ2.
REQ-020 On mem_resp=1 in READ1 with any other op, or in READ2, the formatted data SHALL be captured into rsp_data and the FSM SHALL move to DONE.
REQ-021 Formatting SHALL pass the full word for OP_LDW and OP_LDI; for OP_LDB it SHALL select the byte by latched address bit 0 (0=low, 1=high) and sign-extend it to WIDTH.
REQ-022 DONE SHALL last exactly one cycle with rsp_valid=1 and then return to IDLE; a new request SHALL NOT be accepted in DONE.
REQ-023 Latency SHALL be accept cycle + N memory wait cycles + 1 DONE cycle; with zero-wait memory, rsp_valid SHALL rise 2 cycles after acceptance for OP_LDW and OP_LDB, and 3 cycles for OP_LDI.
REQ-024 stall SHALL be 1 when in IDLE with req_valid=1, or in READ1 or READ2, and 0 otherwise, including in DONE.
REQ-025 mem_resp SHALL be ignored in IDLE and DONE.
REQ-026 rsp_data SHALL hold its last captured value outside DONE.
REQ-027 A flush in READ1 or READ2 SHALL NOT deassert mem_read before mem_resp; the load SHALL complete on the bus, but the transaction is marked dropped.
REQ-028 When a transaction is marked dropped, rsp_valid SHALL stay 0 in DONE, and an OP_LDI SHALL skip READ2 and go to DONE.
REQ-029 A flush in DONE SHALL suppress rsp_valid for that cycle.
REQ-030 A flush in IDLE SHALL block acceptance.

Reset
REQ-031 When rst_n=0 at a clock edge, state SHALL become IDLE, mem_read, rsp_valid and the dropped flag SHALL become 0, and rsp_data and the latched address SHALL become 0.
REQ-032 Reset asserted mid-transaction SHALL abandon it; mem_read SHALL be 0 from the next cycle, and a late mem_resp SHALL be ignored.

Structure
REQ-033 The op encodings and the FSM state enum SHALL live in the shared package mem_load_pkg.
REQ-034 The data formatter SHALL be the single combinational sub-module ld_format (inputs: op, addr bit 0, word; output: formatted word).

Verification
REQ-035 OP_LDW at addr 0x3001 with 2 wait cycles, rdata 0xBEEF -> mem_address 0x3000 held 3 cycles, rsp_valid pulse, rsp_data 0xBEEF.
REQ-036 OP_LDB at addr 0x0041, rdata 0x80FF, zero-wait -> rsp_data 0xFF80, rsp_valid exactly 2 cycles after accept.
REQ-037 OP_LDI at addr 0x1000, rdata 0x2000 then 0x1234 -> second mem_address 0x2000, rsp_data 0x1234, 3-cycle latency.
REQ-038 flush during READ1 of an OP_LDI with 1 wait cycle -> mem_read held until mem_resp, no READ2 access, rsp_valid stays 0.
REQ-039 rst_n=0 in READ2 -> IDLE next cycle, mem_read=0, rsp_data=0; a mem_resp 1 cycle later produces no rsp_valid.
REQ-040 Back-to-back OP_LDW requests -> second accepted the cycle after DONE; stall=0 only in DONE cycles.
